// File: rtl/tt_um_andgate.sv
// TinyTapeout tile: registered bit-wise AND of the dedicated inputs and the
// bidirectional bank, presented on the dedicated outputs one clock later.
module tt_um_andgate (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] result_q;

    // rst_n keeps its harness name but is active-high: 1 clears the result at once
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            result_q <= DATA_W'(0);
        end else if (ena) begin
            result_q <= ui_in & uio_in;
        end
    end

    assign uo_out  = result_q;
    // Bidirectional bank is input-only
    assign uio_out = DATA_W'(0);
    assign uio_oe  = DATA_W'(0);

endmodule

// File: tb/tb_tt_um_andgate.sv
// Directed self-checking bench for tt_um_andgate: reset, AND datapath,
// enable hold, asynchronous reset and a short reference-model run.
module tb_tt_um_andgate;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_andgate dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        rst_n  = 1'b1;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_immediate: got %h want 00", uo_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (uo_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_uo_out cycle %0d: got %h want 00", i, uo_out);
            end
            checks++;
            if (uio_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_uio_out cycle %0d: got %h want 00", i, uio_out);
            end
            checks++;
            if (uio_oe !== 8'h00) begin
                errors++;
                $display("FAIL reset_uio_oe cycle %0d: got %h want 00", i, uio_oe);
            end
        end
    endtask

    task automatic test_basic_and();
        rst_n  = 1'b0;
        ui_in  = 8'hF0;
        uio_in = 8'h3C;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL release_hold: got %h want 00", uo_out);
        end
        tick();
        checks++;
        if (uo_out !== 8'h30) begin
            errors++;
            $display("FAIL basic_f0_3c: got %h want 30", uo_out);
        end
        ui_in  = 8'hAA;
        uio_in = 8'hFF;
        #2;
        checks++;
        if (uo_out !== 8'h30) begin
            errors++;
            $display("FAIL basic_no_comb_path: got %h want 30", uo_out);
        end
        tick();
        checks++;
        if (uo_out !== 8'hAA) begin
            errors++;
            $display("FAIL basic_aa_ff: got %h want AA", uo_out);
        end
    endtask

    task automatic test_corners();
        logic [7:0] a_vec [4];
        logic [7:0] b_vec [4];
        logic [7:0] r_vec [4];
        a_vec = '{8'hFF, 8'h00, 8'h55, 8'h81};
        b_vec = '{8'hFF, 8'hFF, 8'hAA, 8'h01};
        r_vec = '{8'hFF, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) begin
            ui_in  = a_vec[i];
            uio_in = b_vec[i];
            tick();
            checks++;
            if (uo_out !== r_vec[i]) begin
                errors++;
                $display("FAIL corner %h&%h: got %h want %h", a_vec[i], b_vec[i], uo_out, r_vec[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        ena    = 1'b1;
        ui_in  = 8'hF0;
        uio_in = 8'h3C;
        tick();
        checks++;
        if (uo_out !== 8'h30) begin
            errors++;
            $display("FAIL hold_load: got %h want 30", uo_out);
        end
        ena    = 1'b0;
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (uo_out !== 8'h30) begin
                errors++;
                $display("FAIL hold_ena0 edge %0d: got %h want 30", i, uo_out);
            end
        end
        ena = 1'b1;
        tick();
        checks++;
        if (uo_out !== 8'hFF) begin
            errors++;
            $display("FAIL hold_resume: got %h want FF", uo_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_assert: got %h want 00", uo_out);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_release: got %h want 00", uo_out);
        end
        ena = 1'b0;
        tick();
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_disabled_edge: got %h want 00", uo_out);
        end
        ena = 1'b1;
        tick();
        checks++;
        if (uo_out !== 8'hFF) begin
            errors++;
            $display("FAIL async_first_enabled: got %h want FF", uo_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] model;
        model = uo_out === 8'hFF ? 8'hFF : 8'h00;
        for (int i = 0; i < 200; i++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            ena    = 1'($urandom);
            tick();
            if (ena) model = ui_in & uio_in;
            checks++;
            if (uo_out !== model) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", i, uo_out, model);
            end
            checks++;
            if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                errors++;
                $display("FAIL random_uio cycle %0d: oe %h out %h want 00", i, uio_oe, uio_out);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_basic_and();
        test_corners();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
